// File: rtl/addr_rule_pkg.sv
// Shared definitions for the address-range comparator rule programming path:
// command opcodes, sequencer states and config address map helpers.
package addr_rule_pkg;

  typedef enum logic [1:0] {
    OP_WRITE_RULE = 2'd0,
    OP_CLEAR_RULE = 2'd1,
    OP_SET_DSM    = 2'd2,
    OP_CLEAR_ALL  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_W_DIS   = 3'd1,
    ST_W_BASE  = 3'd2,
    ST_W_FLAGS = 3'd3,
    ST_W_SIZE  = 3'd4,
    ST_CLR_ALL = 3'd5,
    ST_W_DSM   = 3'd6,
    ST_RESP    = 3'd7
  } state_e;

  // Field banks of the comparator config space, each NUM_RULES entries deep.
  localparam int FLD_BASE  = 32'sd0;
  localparam int FLD_SIZE  = 32'sd1;
  localparam int FLD_FLAGS = 32'sd2;
  localparam int FLD_DSM   = 32'sd3;

  localparam logic [7:0] CFG_BE_ALL = 8'hFF;

  // Start address of a field bank.
  function automatic int field_offset(input int num_rules, input int field);
    return field * num_rules;
  endfunction

  // Config address of one field of rule k.
  function automatic int rule_cfg_addr(input int num_rules, input int field, input int k);
    return field_offset(num_rules, field) + k;
  endfunction

  // Config address of the single DSM base register.
  function automatic int dsm_cfg_addr(input int num_rules);
    return field_offset(num_rules, FLD_DSM);
  endfunction

endpackage

// File: rtl/addr_rule_prog_ctrl_if.sv
// Host command / response handshake plus comparator config write port.
interface addr_rule_prog_ctrl_if #(
  parameter int NUM_RULES_LOG2 = 5,
  parameter int FLAG_WIDTH     = 32,
  parameter int CFG_WIDTH      = 10
) ();

  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [1:0]                cmd_op;
  logic [NUM_RULES_LOG2-1:0] cmd_index;
  logic [63:0]               cmd_base;
  logic [63:0]               cmd_size;
  logic [FLAG_WIDTH-1:0]     cmd_flags;
  logic                      rsp_valid;
  logic                      rsp_error;
  logic [CFG_WIDTH-1:0]      cfg_address;
  logic                      cfg_write;
  logic [63:0]               cfg_writedata;
  logic [7:0]                cfg_byteenable;

  // Host side: issues commands, observes responses and config traffic.
  modport master (
    output cmd_valid, cmd_op, cmd_index, cmd_base, cmd_size, cmd_flags,
    input  cmd_ready, rsp_valid, rsp_error,
    input  cfg_address, cfg_write, cfg_writedata, cfg_byteenable
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_index, cmd_base, cmd_size, cmd_flags,
    output cmd_ready, rsp_valid, rsp_error,
    output cfg_address, cfg_write, cfg_writedata, cfg_byteenable
  );

endinterface

// File: rtl/addr_rule_prog_ctrl.sv
// Rule RAM programming sequencer: turns one host command into an ordered
// series of 64-bit config writes. A rule update first zeroes the size (rule
// disabled), then writes base and flags, and only enables the rule with the
// final size write, so a lookup never sees a half-written rule.
module addr_rule_prog_ctrl
  import addr_rule_pkg::*;
#(
  parameter int NUM_RULES      = 32,
  parameter int NUM_RULES_LOG2 = 5,
  parameter int FLAG_WIDTH     = 32,
  parameter int CFG_WIDTH      = 10
) (
  input logic                 clk,
  input logic                 reset,
  addr_rule_prog_ctrl_if.slave bus
);

  localparam logic [NUM_RULES_LOG2-1:0] LAST_RULE = NUM_RULES_LOG2'(NUM_RULES - 1);

  state_e                    r_state, w_state_nxt;
  op_e                       r_op, w_op_nxt;
  logic [NUM_RULES_LOG2-1:0] r_index, w_index_nxt;
  logic [NUM_RULES_LOG2-1:0] r_cnt, w_cnt_nxt;
  logic [63:0]               r_base, w_base_nxt;
  logic [63:0]               r_size, w_size_nxt;
  logic [FLAG_WIDTH-1:0]     r_flags, w_flags_nxt;
  logic                      r_err, w_err_nxt;
  logic                      r_ready;

  logic                      w_accept;
  logic                      w_is_rule_op;
  logic                      w_bad_index;
  logic                      w_carry;
  logic                      w_reject;
  logic [31:0]               w_index_ext;

  logic [CFG_WIDTH-1:0]      r_cfg_address, w_cfg_address;
  logic                      r_cfg_write, w_cfg_write;
  logic [63:0]               r_cfg_writedata, w_cfg_writedata;
  logic [7:0]                r_cfg_byteenable;
  logic                      r_rsp_valid;
  logic                      r_rsp_error;

  // Config address of a field for a given rule index.
  function automatic logic [CFG_WIDTH-1:0] addr_of(input int field,
                                                   input logic [NUM_RULES_LOG2-1:0] k);
    return CFG_WIDTH'(rule_cfg_addr(NUM_RULES, field, int'(k)));
  endfunction

  // Ready is forced low while reset is held so nothing is accepted then.
  assign bus.cmd_ready      = r_ready & ~reset;
  assign w_accept           = bus.cmd_valid & bus.cmd_ready;

  // Validation of the presented command.
  assign w_is_rule_op = (bus.cmd_op == OP_WRITE_RULE) || (bus.cmd_op == OP_CLEAR_RULE);
  assign w_index_ext  = 32'(bus.cmd_index);
  assign w_bad_index  = w_is_rule_op && (w_index_ext >= 32'(NUM_RULES));
  // base + size carries out of 64 bits exactly when size > ~base.
  assign w_carry      = (bus.cmd_op == OP_WRITE_RULE) && (bus.cmd_size > ~bus.cmd_base);
  assign w_reject     = w_bad_index | w_carry;

  assign bus.cfg_address    = r_cfg_address;
  assign bus.cfg_write      = r_cfg_write;
  assign bus.cfg_writedata  = r_cfg_writedata;
  assign bus.cfg_byteenable = r_cfg_byteenable;
  assign bus.rsp_valid      = r_rsp_valid;
  assign bus.rsp_error      = r_rsp_error;

  // Next-state logic, command latching and clear-all counter.
  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_index_nxt = r_index;
    w_cnt_nxt   = r_cnt;
    w_base_nxt  = r_base;
    w_size_nxt  = r_size;
    w_flags_nxt = r_flags;
    w_err_nxt   = r_err;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_op_nxt    = op_e'(bus.cmd_op);
          w_index_nxt = bus.cmd_index;
          w_base_nxt  = bus.cmd_base;
          w_size_nxt  = bus.cmd_size;
          w_flags_nxt = bus.cmd_flags;
          w_err_nxt   = w_reject;
          w_cnt_nxt   = '0;
          if (w_reject) begin
            w_state_nxt = ST_RESP;
          end else begin
            case (op_e'(bus.cmd_op))
              OP_WRITE_RULE: w_state_nxt = ST_W_DIS;
              OP_CLEAR_RULE: w_state_nxt = ST_W_DIS;
              OP_SET_DSM:    w_state_nxt = ST_W_DSM;
              OP_CLEAR_ALL:  w_state_nxt = ST_CLR_ALL;
              default:       w_state_nxt = ST_RESP;
            endcase
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_W_DIS: begin
        if (r_op == OP_WRITE_RULE) begin
          w_state_nxt = ST_W_BASE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_W_BASE:  w_state_nxt = ST_W_FLAGS;
      ST_W_FLAGS: w_state_nxt = ST_W_SIZE;
      ST_W_SIZE:  w_state_nxt = ST_RESP;
      ST_W_DSM:   w_state_nxt = ST_RESP;
      ST_CLR_ALL: begin
        // Leave on the last index so the counter never wraps into a 33rd write.
        if (r_cnt == LAST_RULE) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_cnt_nxt = r_cnt + NUM_RULES_LOG2'(1);
        end
      end
      ST_RESP:    w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Config write for the upcoming state, registered on the next edge.
  always_comb begin
    w_cfg_write     = 1'b0;
    w_cfg_address   = '0;
    w_cfg_writedata = 64'd0;
    case (w_state_nxt)
      ST_W_DIS: begin
        w_cfg_write   = 1'b1;
        w_cfg_address = addr_of(FLD_SIZE, w_index_nxt);
      end
      ST_W_BASE: begin
        w_cfg_write     = 1'b1;
        w_cfg_address   = addr_of(FLD_BASE, w_index_nxt);
        w_cfg_writedata = w_base_nxt;
      end
      ST_W_FLAGS: begin
        w_cfg_write     = 1'b1;
        w_cfg_address   = addr_of(FLD_FLAGS, w_index_nxt);
        w_cfg_writedata = 64'(w_flags_nxt);
      end
      ST_W_SIZE: begin
        w_cfg_write     = 1'b1;
        w_cfg_address   = addr_of(FLD_SIZE, w_index_nxt);
        w_cfg_writedata = w_size_nxt;
      end
      ST_W_DSM: begin
        w_cfg_write     = 1'b1;
        w_cfg_address   = CFG_WIDTH'(dsm_cfg_addr(NUM_RULES));
        w_cfg_writedata = w_base_nxt;
      end
      ST_CLR_ALL: begin
        w_cfg_write   = 1'b1;
        w_cfg_address = addr_of(FLD_SIZE, w_cnt_nxt);
      end
      default: begin
        w_cfg_write = 1'b0;
      end
    endcase
  end

  // State, latched command and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= ST_IDLE;
      r_op             <= OP_WRITE_RULE;
      r_index          <= '0;
      r_cnt            <= '0;
      r_base           <= 64'd0;
      r_size           <= 64'd0;
      r_flags          <= '0;
      r_err            <= 1'b0;
      r_ready          <= 1'b1;
      r_cfg_address    <= '0;
      r_cfg_write      <= 1'b0;
      r_cfg_writedata  <= 64'd0;
      r_cfg_byteenable <= 8'h00;
      r_rsp_valid      <= 1'b0;
      r_rsp_error      <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_op             <= w_op_nxt;
      r_index          <= w_index_nxt;
      r_cnt            <= w_cnt_nxt;
      r_base           <= w_base_nxt;
      r_size           <= w_size_nxt;
      r_flags          <= w_flags_nxt;
      r_err            <= w_err_nxt;
      r_ready          <= (w_state_nxt == ST_IDLE);
      r_cfg_address    <= w_cfg_address;
      r_cfg_write      <= w_cfg_write;
      r_cfg_writedata  <= w_cfg_writedata;
      r_cfg_byteenable <= w_cfg_write ? CFG_BE_ALL : 8'h00;
      r_rsp_valid      <= (w_state_nxt == ST_RESP);
      r_rsp_error      <= (w_state_nxt == ST_RESP) & w_err_nxt;
    end
  end

endmodule

// File: tb/tb_addr_rule_prog_ctrl.sv
// Self-checking bench for addr_rule_prog_ctrl: table of single commands with
// hand-computed write sequences, plus hand-written multi-cycle sequences.
module tb_addr_rule_prog_ctrl;

  logic clk = 1'b0;
  logic reset;

  addr_rule_prog_ctrl_if #(.NUM_RULES_LOG2(5), .FLAG_WIDTH(32), .CFG_WIDTH(10)) bus ();
  addr_rule_prog_ctrl_if #(.NUM_RULES_LOG2(6), .FLAG_WIDTH(32), .CFG_WIDTH(10)) bus40 ();

  addr_rule_prog_ctrl #(.NUM_RULES(32), .NUM_RULES_LOG2(5), .FLAG_WIDTH(32), .CFG_WIDTH(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  addr_rule_prog_ctrl #(.NUM_RULES(40), .NUM_RULES_LOG2(6), .FLAG_WIDTH(32), .CFG_WIDTH(10)) dut40 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus40)
  );

  always #5 clk = ~clk;

  // Comparator-side view of rule 3's size register.
  logic [63:0] rule3_size = 64'd0;
  always @(posedge clk) begin
    if (bus.cfg_write === 1'b1 && bus.cfg_address == 10'd35) rule3_size <= bus.cfg_writedata;
  end

  typedef struct {
    logic [1:0]        op;
    logic [4:0]        idx;
    logic [63:0]       base;
    logic [63:0]       size;
    logic [31:0]       flags;
    logic              exp_err;
    int                lat;
    int                nw;
    logic [0:3][9:0]   wa;
    logic [0:3][63:0]  wd;
  } vec_t;

  vec_t vecs [7];
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0b expected %0b", nm, act, exp);
  endtask

  task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [4:0] idx,
                              input logic [63:0] base, input logic [63:0] size,
                              input logic [31:0] flags, input logic err, input int lat,
                              input int nw, input logic [0:3][9:0] wa,
                              input logic [0:3][63:0] wd);
    vec_t v;
    v.op = op; v.idx = idx; v.base = base; v.size = size; v.flags = flags;
    v.exp_err = err; v.lat = lat; v.nw = nw; v.wa = wa; v.wd = wd;
    return v;
  endfunction

  task automatic wait_ready(input string nm);
    int k = 0;
    while (bus.cmd_ready !== 1'b1 && k < 64) begin
      @(negedge clk);
      k++;
    end
    chk1(nm, bus.cmd_ready, 1'b1);
  endtask

  task automatic run_vec(input int i, input vec_t v);
    logic wr_exp;
    wait_ready($sformatf("v%0d_ready", i));
    bus.cmd_op    = v.op;
    bus.cmd_index = v.idx;
    bus.cmd_base  = v.base;
    bus.cmd_size  = v.size;
    bus.cmd_flags = v.flags;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    for (int c = 1; c <= v.lat + 1; c++) begin
      if (c > 1) @(negedge clk);
      wr_exp = (c <= v.nw);
      chk1($sformatf("v%0d_c%0d_write", i, c), bus.cfg_write, wr_exp);
      if (wr_exp) begin
        chk64($sformatf("v%0d_c%0d_addr", i, c), 64'(bus.cfg_address), 64'(v.wa[c-1]));
        chk64($sformatf("v%0d_c%0d_data", i, c), bus.cfg_writedata, v.wd[c-1]);
        chk64($sformatf("v%0d_c%0d_be", i, c), 64'(bus.cfg_byteenable), 64'hFF);
      end else begin
        chk64($sformatf("v%0d_c%0d_be", i, c), 64'(bus.cfg_byteenable), 64'h0);
      end
      chk1($sformatf("v%0d_c%0d_rsp_valid", i, c), bus.rsp_valid, c == v.lat);
      if (c == v.lat) chk1($sformatf("v%0d_rsp_error", i), bus.rsp_error, v.exp_err);
      chk1($sformatf("v%0d_c%0d_ready", i, c), bus.cmd_ready, c == v.lat + 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = mk(2'd0, 5'd3, 64'h1000, 64'h100, 32'h5, 1'b0, 5, 4,
                 {10'd35, 10'd3, 10'd67, 10'd35}, {64'h0, 64'h1000, 64'h5, 64'h100});
    vecs[1] = mk(2'd0, 5'd5, 64'hFFFF_FFFF_FFFF_F000, 64'h1000, 32'h1, 1'b1, 1, 0,
                 {10'd0, 10'd0, 10'd0, 10'd0}, {64'h0, 64'h0, 64'h0, 64'h0});
    vecs[2] = mk(2'd0, 5'd7, 64'hFFFF_FFFF_FFFF_F000, 64'hFFF, 32'hA5, 1'b0, 5, 4,
                 {10'd39, 10'd7, 10'd71, 10'd39},
                 {64'h0, 64'hFFFF_FFFF_FFFF_F000, 64'hA5, 64'hFFF});
    vecs[3] = mk(2'd1, 5'd31, 64'h1234, 64'h55, 32'h7, 1'b0, 2, 1,
                 {10'd63, 10'd0, 10'd0, 10'd0}, {64'h0, 64'h0, 64'h0, 64'h0});
    vecs[4] = mk(2'd2, 5'd0, 64'hABCD_0000, 64'h0, 32'h0, 1'b0, 2, 1,
                 {10'd96, 10'd0, 10'd0, 10'd0}, {64'hABCD_0000, 64'h0, 64'h0, 64'h0});
    vecs[5] = mk(2'd0, 5'd0, 64'h0, 64'h0, 32'hFFFF_FFFF, 1'b0, 5, 4,
                 {10'd32, 10'd0, 10'd64, 10'd32}, {64'h0, 64'h0, 64'hFFFF_FFFF, 64'h0});
    vecs[6] = mk(2'd0, 5'd31, 64'h8000_0000, 64'h10, 32'h8000_0000, 1'b0, 5, 4,
                 {10'd63, 10'd31, 10'd95, 10'd63},
                 {64'h0, 64'h8000_0000, 64'h8000_0000, 64'h10});

    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_index = 5'd0;
    bus.cmd_base = 64'd0; bus.cmd_size = 64'd0; bus.cmd_flags = 32'd0;
    bus40.cmd_valid = 1'b0; bus40.cmd_op = 2'd0; bus40.cmd_index = 6'd0;
    bus40.cmd_base = 64'd0; bus40.cmd_size = 64'd0; bus40.cmd_flags = 32'd0;

    // Reset held for three cycles.
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk1($sformatf("rst%0d_write", c), bus.cfg_write, 1'b0);
      chk1($sformatf("rst%0d_rsp_valid", c), bus.rsp_valid, 1'b0);
      chk1($sformatf("rst%0d_ready", c), bus.cmd_ready, 1'b0);
      chk64($sformatf("rst%0d_addr", c), 64'(bus.cfg_address), 64'h0);
      chk64($sformatf("rst%0d_data", c), bus.cfg_writedata, 64'h0);
      chk64($sformatf("rst%0d_be", c), 64'(bus.cfg_byteenable), 64'h0);
    end
    reset = 1'b0;
    #1;
    chk1("rst_release_ready", bus.cmd_ready, 1'b1);
    chk1("rst_release_rsp", bus.rsp_valid, 1'b0);
    chk1("rst_release_ready40", bus40.cmd_ready, 1'b1);

    // Table of single commands.
    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // SET_DSM with cmd_valid held: second acceptance only once ready returns.
    wait_ready("dsm_hold_ready");
    bus.cmd_op = 2'd2; bus.cmd_base = 64'hABCD_0000; bus.cmd_index = 5'd9;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    chk1("dsm_t1_write", bus.cfg_write, 1'b1);
    chk64("dsm_t1_addr", 64'(bus.cfg_address), 64'd96);
    chk64("dsm_t1_data", bus.cfg_writedata, 64'hABCD_0000);
    chk1("dsm_t1_ready", bus.cmd_ready, 1'b0);
    @(negedge clk);
    chk1("dsm_t2_write", bus.cfg_write, 1'b0);
    chk1("dsm_t2_rsp", bus.rsp_valid, 1'b1);
    chk1("dsm_t2_err", bus.rsp_error, 1'b0);
    chk1("dsm_t2_ready", bus.cmd_ready, 1'b0);
    @(negedge clk);
    chk1("dsm_t3_ready", bus.cmd_ready, 1'b1);
    chk1("dsm_t3_write", bus.cfg_write, 1'b0);
    chk1("dsm_t3_rsp", bus.rsp_valid, 1'b0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk1("dsm_t4_write", bus.cfg_write, 1'b1);
    chk64("dsm_t4_addr", 64'(bus.cfg_address), 64'd96);
    chk1("dsm_t4_ready", bus.cmd_ready, 1'b0);
    @(negedge clk);
    chk1("dsm_t5_rsp", bus.rsp_valid, 1'b1);
    @(negedge clk);
    chk1("dsm_t6_ready", bus.cmd_ready, 1'b1);
    chk1("dsm_t6_rsp", bus.rsp_valid, 1'b0);

    // Reset in the middle of a WRITE_RULE to rule 3.
    chk64("rule3_size_before", rule3_size, 64'h100);
    wait_ready("midrst_ready");
    bus.cmd_op = 2'd0; bus.cmd_index = 5'd3; bus.cmd_base = 64'h2000;
    bus.cmd_size = 64'h200; bus.cmd_flags = 32'h1; bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk64("midrst_t1_addr", 64'(bus.cfg_address), 64'd35);
    chk1("midrst_t1_write", bus.cfg_write, 1'b1);
    @(negedge clk);
    chk64("midrst_t2_addr", 64'(bus.cfg_address), 64'd3);
    chk64("midrst_t2_data", bus.cfg_writedata, 64'h2000);
    reset = 1'b1;
    @(negedge clk);
    chk1("midrst_t3_write", bus.cfg_write, 1'b0);
    chk1("midrst_t3_rsp", bus.rsp_valid, 1'b0);
    reset = 1'b0;
    for (int c = 4; c < 10; c++) begin
      @(negedge clk);
      chk1($sformatf("midrst_t%0d_write", c), bus.cfg_write, 1'b0);
      chk1($sformatf("midrst_t%0d_rsp", c), bus.rsp_valid, 1'b0);
    end
    chk64("rule3_size_disabled", rule3_size, 64'h0);

    // CLEAR_ALL: 32 size writes then a response.
    wait_ready("clrall_ready");
    bus.cmd_op = 2'd3; bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      if (c > 1) @(negedge clk);
      chk1($sformatf("clrall_c%0d_write", c), bus.cfg_write, c <= 32);
      if (c <= 32) begin
        chk64($sformatf("clrall_c%0d_addr", c), 64'(bus.cfg_address), 64'(31 + c));
        chk64($sformatf("clrall_c%0d_data", c), bus.cfg_writedata, 64'h0);
      end
      chk1($sformatf("clrall_c%0d_rsp", c), bus.rsp_valid, c == 33);
    end
    chk1("clrall_ready_back", bus.cmd_ready, 1'b1);

    // NUM_RULES=40 build: index 40 rejected, index 39 accepted.
    chk1("n40_ready", bus40.cmd_ready, 1'b1);
    bus40.cmd_op = 2'd0; bus40.cmd_index = 6'd40; bus40.cmd_size = 64'h10;
    bus40.cmd_valid = 1'b1;
    @(negedge clk);
    bus40.cmd_valid = 1'b0;
    chk1("n40_bad_rsp", bus40.rsp_valid, 1'b1);
    chk1("n40_bad_err", bus40.rsp_error, 1'b1);
    chk1("n40_bad_write", bus40.cfg_write, 1'b0);
    @(negedge clk);
    chk1("n40_bad_ready", bus40.cmd_ready, 1'b1);
    bus40.cmd_op = 2'd1; bus40.cmd_index = 6'd39; bus40.cmd_valid = 1'b1;
    @(negedge clk);
    bus40.cmd_valid = 1'b0;
    chk1("n40_clr_write", bus40.cfg_write, 1'b1);
    chk64("n40_clr_addr", 64'(bus40.cfg_address), 64'd79);
    @(negedge clk);
    chk1("n40_clr_rsp", bus40.rsp_valid, 1'b1);
    chk1("n40_clr_err", bus40.rsp_error, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
